io_bridge: RTL and testbench
============================

IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter NUBITS, 16, processor word width.
REQ-002 Parameter NBIOIN, 2, processor input-port address width.
REQ-003 Parameter NBIOOU, 2, processor output-port address width.
REQ-004 Parameter IDEPTH, 4, rx FIFO depth in words (power of 2, at least 2).
REQ-005 Parameter ODEPTH, 4, tx FIFO depth in words (power of 2, at least 2).
REQ-006 Parameter ITREN, 1, enables the itr pulse; when 0, itr is held at 0.
REQ-007 One clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-008 clk  in  1  clock, rising edge.
REQ-009 rst  in  1  asynchronous reset, active-high.
REQ-010 addr_in  in  NBIOIN  processor input-port address.
REQ-011 req_in  in  1  processor read strobe.
REQ-012 io_in  out  NUBITS  read data to the processor.
REQ-013 addr_out  in  NBIOOU  processor output-port address.
REQ-014 out_en  in  1  processor write strobe.
REQ-015 io_out  in  NUBITS  write data from the processor.
REQ-016 itr  out  1  interrupt pulse to the processor.
REQ-017 rx_data  in  NUBITS  external input stream data.
REQ-018 rx_valid  in  1  rx_data is valid.
REQ-019 rx_ready  out  1  rx FIFO can accept a word.
REQ-020 tx_data  out  NUBITS  external output stream data.
REQ-021 tx_valid  out  1  tx_data is valid.
REQ-022 tx_ready  in  1  external consumer accepts tx_data.
REQ-023 gpi  in  (2**NBIOIN-2)*NUBITS  static inputs for ports 1..2**NBIOIN-2; port k occupies slice k-1.
REQ-024 gpo  out  (2**NBIOOU-1)*NUBITS  registered outputs for ports 1..2**NBIOOU-1; port k occupies slice k-1.

Function
REQ-025 Input port 0 SHALL be the rx FIFO head, input ports 1..2**NBIOIN-2 SHALL be gpi, and input port all-ones SHALL be STATUS.
REQ-026 STATUS SHALL read {zeros, udf, ovf, tx_full, rx_nonempty} in bits 3..0.
REQ-027 io_in SHALL be a combinational mux of addr_in over registered sources, valid in the same cycle req_in is high, and SHALL be 0 when req_in is low.
REQ-028 A read with req_in=1 and addr_in=0 SHALL pop the rx FIFO at the clock edge; if the FIFO is empty, it SHALL return 0 and set sticky udf.
REQ-029 A read with req_in=1 and addr_in=STATUS SHALL return the current flags and clear udf and ovf at the clock edge; a flag event in the same cycle SHALL win, leaving the flag set.
REQ-030 A write with out_en=1 and addr_out=0 SHALL push io_out into the tx FIFO; if the FIFO is full, the word SHALL be dropped and sticky ovf set.
REQ-031 A write with out_en=1 and addr_out=k>0 SHALL load gpo slice k-1 at the clock edge, visible 1 cycle later.
REQ-032 rx push SHALL occur on rx_valid&rx_ready; rx_ready SHALL be high exactly when the rx FIFO is not full.
REQ-033 tx pop SHALL occur on tx_valid&tx_ready; tx_valid SHALL be high exactly when the tx FIFO is not empty; tx_data SHALL be the FIFO head, held stable while tx_valid is high and tx_ready is low.
REQ-034 A simultaneous push and pop on a full FIFO SHALL be legal for rx and tx: count unchanged, no flag set.
REQ-035 A simultaneous push and pop on an empty FIFO SHALL NOT bypass: the pop SHALL see empty (udf for rx) and the pushed word SHALL be stored.
REQ-036 FIFO pointers SHALL wrap modulo depth; the count SHALL be log2(depth)+1 bits wide.
REQ-037 itr SHALL be a registered one-cycle pulse, asserted the cycle after the rx count transitions from 0 to nonzero; it SHALL NOT pulse while the count stays nonzero.
REQ-038 Minimum latency SHALL be: rx word to processor-readable 1 cycle after the push edge; processor write to tx_valid 1 cycle after the out_en edge.

Reset
REQ-039 rst SHALL asynchronously empty both FIFOs and clear ovf, udf, gpo, itr and tx_valid to 0; rx_ready SHALL be 1 after reset.
REQ-040 rst asserted mid-transfer SHALL discard all FIFO contents with no partial word emitted; outputs SHALL take their reset values while rst is high.

Structure
REQ-041 A shared package/include SHALL hold the STATUS bit indices and the port-0 and STATUS address constants.
REQ-042 One sub-module io_fifo (parameters NBDATA and DEPTH; push, pop, full, empty, count, head) SHALL be instantiated twice, for rx and tx.
REQ-043 Total RTL SHALL be 120-400 lines; no latches; all state SHALL be on clk with async rst.

Verification
REQ-044 Push 0x1111, 0x2222 on rx; read port 0 twice -> io_in=0x1111 then 0x2222; itr pulses exactly once.
REQ-045 Read port 0 with the FIFO empty -> io_in=0; STATUS reads 0x8; an immediate second STATUS read returns 0x0.
REQ-046 With tx_ready=0 and ODEPTH=4, write 5 words -> tx_full=1, ovf=1; release tx_ready -> exactly words 1-4 appear in order.
REQ-047 With the rx FIFO full, drive rx push and processor pop in the same cycle -> count stays 4, rx_ready stays 0, data order preserved.
REQ-048 Write 0xBEEF to port 2 -> gpo slice 1 = 0xBEEF 1 cycle later; a read of port 1 returns gpi slice 0.
REQ-049 Assert rst with 3 words in each FIFO -> tx_valid=0, STATUS=0, gpo=0 immediately; no stale word after rst is released.

Source files
------------

// File: rtl/io_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bridge_pkg
//  Description : Shared constants for the processor I/O bridge: STATUS word
//                bit positions and the fixed port addresses (FIFO port 0 and
//                the all-ones STATUS port).
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bridge_pkg;

    // STATUS word layout (upper bits read as zero)
    localparam int c_ST_RX_NONEMPTY = 0;
    localparam int c_ST_TX_FULL     = 1;
    localparam int c_ST_OVF         = 2;
    localparam int c_ST_UDF         = 3;

    // Port 0 is the FIFO port on both the input and the output side
    localparam int c_PORT_FIFO = 0;

    // STATUS lives at the all-ones input address for a given address width
    function automatic int unsigned status_addr(input int unsigned nbits);
        return (1 << nbits) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_fifo
//  Description : Synchronous FIFO, power-of-2 depth, async active-high reset.
//                A push while full is accepted only if a pop happens in the
//                same cycle; a pop while empty is ignored (no bypass).
//  Ports       : clk, rst      - clock / async reset
//                push, wdata   - write request and data
//                pop           - read request (advances head)
//                full, empty   - occupancy flags
//                count         - words stored, log2(DEPTH)+1 bits
//                head          - oldest stored word
//  Revision    : 1.0 - initial release
// ============================================================================
module io_fifo #(
    parameter int NBDATA = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [NBDATA-1:0]        wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [NBDATA-1:0]        head
);

    localparam int c_AW = $clog2(DEPTH);

    logic [NBDATA-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_AW+1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    // A full FIFO can take a word only when the head leaves in the same cycle
    assign w_do_push = push & (~full | w_do_pop);
    assign count     = r_count;
    assign head      = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + 1'b1;   // wraps modulo DEPTH
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : io_bridge
//  Description : Processor I/O bridge. Input port 0 pops the rx FIFO, ports
//                1..2**NBIOIN-2 read gpi, the all-ones port reads STATUS
//                (clear-on-read udf/ovf). Output port 0 pushes the tx FIFO,
//                ports 1..2**NBIOOU-1 load gpo registers. itr pulses when the
//                rx FIFO goes from empty to non-empty.
//  Ports       : clk, rst                    - clock / async reset
//                addr_in, req_in, io_in      - processor read side
//                addr_out, out_en, io_out    - processor write side
//                itr                         - interrupt pulse
//                rx_data/rx_valid/rx_ready   - inbound stream
//                tx_data/tx_valid/tx_ready   - outbound stream
//                gpi, gpo                    - static inputs / registered outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int NBIOIN = 2,
    parameter int NBIOOU = 2,
    parameter int IDEPTH = 4,
    parameter int ODEPTH = 4,
    parameter int ITREN  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NBIOIN-1:0]                 addr_in,
    input  logic                              req_in,
    output logic [NUBITS-1:0]                 io_in,
    input  logic [NBIOOU-1:0]                 addr_out,
    input  logic                              out_en,
    input  logic [NUBITS-1:0]                 io_out,
    output logic                              itr,
    input  logic [NUBITS-1:0]                 rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    output logic [NUBITS-1:0]                 tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    input  logic [(2**NBIOIN-2)*NUBITS-1:0]   gpi,
    output logic [(2**NBIOOU-1)*NUBITS-1:0]   gpo
);

    localparam int                c_NGPI      = 2**NBIOIN - 2;
    localparam int                c_NGPO      = 2**NBIOOU - 1;
    localparam logic [NBIOIN-1:0] c_STATUS_IN = NBIOIN'(status_addr(NBIOIN));

    logic                      w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
    logic [$clog2(IDEPTH):0]   w_rx_count;
    logic [$clog2(ODEPTH):0]   w_tx_count;
    logic [NUBITS-1:0]         w_rx_head;
    logic                      w_rx_rd, w_st_rd, w_tx_wr, w_tx_pop;
    logic                      w_udf_evt, w_ovf_evt;
    logic [NUBITS-1:0]         w_status;
    logic                      w_unused;

    logic                      r_udf, r_ovf, r_itr;
    logic [c_NGPO*NUBITS-1:0]  r_gpo;

    assign w_rx_rd   = req_in & (addr_in == NBIOIN'(c_PORT_FIFO));
    assign w_st_rd   = req_in & (addr_in == c_STATUS_IN);
    assign w_tx_wr   = out_en & (addr_out == NBIOOU'(c_PORT_FIFO));
    assign w_tx_pop  = tx_ready & ~w_tx_empty;
    assign w_udf_evt = w_rx_rd & w_rx_empty;
    // A write into a full tx FIFO is lost unless the consumer drains a word
    // in the same cycle
    assign w_ovf_evt = w_tx_wr & w_tx_full & ~w_tx_pop;
    assign w_unused  = ^{w_rx_count, w_tx_count};

    // rx_valid is offered to the FIFO directly: a word arriving while full is
    // still taken if the processor pops in the same cycle
    io_fifo #(.NBDATA(NUBITS), .DEPTH(IDEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (w_rx_rd),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .count (w_rx_count),
        .head  (w_rx_head)
    );

    io_fifo #(.NBDATA(NUBITS), .DEPTH(ODEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tx_wr),
        .wdata (io_out),
        .pop   (tx_ready),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .count (w_tx_count),
        .head  (tx_data)
    );

    assign rx_ready = ~w_rx_full;
    assign tx_valid = ~w_tx_empty;
    assign itr      = r_itr;
    assign gpo      = r_gpo;

    always_comb begin
        w_status                   = '0;
        w_status[c_ST_RX_NONEMPTY] = ~w_rx_empty;
        w_status[c_ST_TX_FULL]     = w_tx_full;
        w_status[c_ST_OVF]         = r_ovf;
        w_status[c_ST_UDF]         = r_udf;
    end

    always_comb begin
        io_in = '0;
        if (req_in) begin
            if (addr_in == NBIOIN'(c_PORT_FIFO)) begin
                io_in = w_rx_empty ? '0 : w_rx_head;
            end else if (addr_in == c_STATUS_IN) begin
                io_in = w_status;
            end else begin
                for (int k = 1; k <= c_NGPI; k++) begin
                    if (addr_in == NBIOIN'(k)) begin
                        io_in = gpi[(k-1)*NUBITS +: NUBITS];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_udf <= 1'b0;
            r_ovf <= 1'b0;
            r_itr <= 1'b0;
            r_gpo <= '0;
        end else begin
            // A new event beats the clear-on-read of STATUS
            r_udf <= w_udf_evt | (r_udf & ~w_st_rd);
            r_ovf <= w_ovf_evt | (r_ovf & ~w_st_rd);
            // An empty FIFO always accepts rx_valid, so this is exactly the
            // count leaving zero
            r_itr <= (ITREN != 0) & w_rx_empty & rx_valid;
            for (int k = 1; k <= c_NGPO; k++) begin
                if (out_en && (addr_out == NBIOOU'(k))) begin
                    r_gpo[(k-1)*NUBITS +: NUBITS] <= io_out;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bridge
//  Description : Self-checking bench for io_bridge. A queue-based reference
//                model predicts every output each cycle; directed scenarios
//                are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bridge;

    localparam int NUBITS = 16;
    localparam int NBIOIN = 2;
    localparam int NBIOOU = 2;
    localparam int IDEPTH = 4;
    localparam int ODEPTH = 4;
    localparam int NGPI   = 2**NBIOIN - 2;
    localparam int NGPO   = 2**NBIOOU - 1;
    localparam logic [NBIOIN-1:0] ST = '1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NBIOIN-1:0]        addr_in;
    logic                     req_in;
    logic [NUBITS-1:0]        io_in;
    logic [NBIOOU-1:0]        addr_out;
    logic                     out_en;
    logic [NUBITS-1:0]        io_out;
    logic                     itr;
    logic [NUBITS-1:0]        rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [NUBITS-1:0]        tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [NGPI*NUBITS-1:0]   gpi;
    logic [NGPO*NUBITS-1:0]   gpo;

    io_bridge #(
        .NUBITS(NUBITS), .NBIOIN(NBIOIN), .NBIOOU(NBIOOU),
        .IDEPTH(IDEPTH), .ODEPTH(ODEPTH), .ITREN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .req_in(req_in), .io_in(io_in),
        .addr_out(addr_out), .out_en(out_en), .io_out(io_out),
        .itr(itr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .gpi(gpi), .gpo(gpo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int itr_pulses = 0;

    // reference model state
    logic [NUBITS-1:0] rxq[$];
    logic [NUBITS-1:0] txq[$];
    logic [NUBITS-1:0] txlog[$];
    logic [NUBITS-1:0] m_gpo [NGPO];
    logic              m_ovf, m_udf, m_itr;

    always @(negedge clk) if (itr === 1'b1) itr_pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUBITS-1:0] exp_io();
        logic [NUBITS-1:0] v;
        v = '0;
        if (!req_in) return '0;
        if (addr_in == 0) return (rxq.size() != 0) ? rxq[0] : '0;
        if (addr_in == ST) begin
            v[3] = m_udf;
            v[2] = m_ovf;
            v[1] = (txq.size() == ODEPTH);
            v[0] = (rxq.size() != 0);
            return v;
        end
        return gpi[(int'(addr_in)-1)*NUBITS +: NUBITS];
    endfunction

    function automatic logic [NGPO*NUBITS-1:0] exp_gpo();
        logic [NGPO*NUBITS-1:0] v;
        for (int k = 0; k < NGPO; k++) v[k*NUBITS +: NUBITS] = m_gpo[k];
        return v;
    endfunction

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        for (int k = 0; k < NGPO; k++) m_gpo[k] = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_itr = 1'b0;
    endtask

    task automatic idle();
        req_in   = 1'b0; addr_in  = '0;
        out_en   = 1'b0; addr_out = '0; io_out = '0;
        rx_valid = 1'b0; rx_data  = '0;
        tx_ready = 1'b0;
    endtask

    // Called at a falling edge with inputs already driven: check outputs,
    // advance the model by one clock, then return at the next falling edge.
    task automatic step();
        bit rd0, rdst, rxpop, rxpush, txreq, txpop, txpush;
        #1;
        chk("io_in", io_in, exp_io());
        chk("rx_ready", rx_ready, rxq.size() < IDEPTH);
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("itr", itr, m_itr);
        chk("gpo", gpo, exp_gpo());
        if (tx_valid && tx_ready) txlog.push_back(tx_data);

        rd0    = req_in && (addr_in == 0);
        rdst   = req_in && (addr_in == ST);
        rxpop  = rd0 && (rxq.size() != 0);
        rxpush = rx_valid && ((rxq.size() < IDEPTH) || rxpop);
        txreq  = out_en && (addr_out == 0);
        txpop  = tx_ready && (txq.size() != 0);
        txpush = txreq && ((txq.size() < ODEPTH) || txpop);
        m_itr  = rxpush && (rxq.size() == 0);
        m_udf  = (rd0 && (rxq.size() == 0)) || (m_udf && !rdst);
        m_ovf  = (txreq && !txpush) || (m_ovf && !rdst);
        if (rxpop)  void'(rxq.pop_front());
        if (rxpush) rxq.push_back(rx_data);
        if (txpop)  void'(txq.pop_front());
        if (txpush) txq.push_back(io_out);
        if (out_en && (addr_out != 0)) m_gpo[int'(addr_out)-1] = io_out;

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        gpi = NGPI*NUBITS'($urandom);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state: STATUS reads zero, rx_ready high, tx_valid low
        req_in = 1'b1; addr_in = ST;
        #1 chk("reset_status", io_in, 16'h0000);
        chk("reset_rx_ready", rx_ready, 1'b1);
        step();

        // Two rx words, read back in order, one itr pulse
        idle();
        itr_pulses = 0;
        rx_valid = 1'b1; rx_data = 16'h1111; step();
        rx_data = 16'h2222; step();
        idle();
        req_in = 1'b1; addr_in = 0;
        #1 chk("rd_first", io_in, 16'h1111);
        step();
        chk("rd_second", io_in, 16'h2222);
        step();
        idle(); step();
        chk("itr_once", itr_pulses, 1);

        // Empty read -> 0 and udf; STATUS 0x8 then 0x0
        req_in = 1'b1; addr_in = 0;
        #1 chk("empty_rd", io_in, 16'h0000);
        step();
        addr_in = ST;
        #1 chk("status_udf", io_in, 16'h0008);
        step();
        #1 chk("status_clr", io_in, 16'h0000);
        step();

        // tx overflow with consumer stalled, then drain in order
        idle();
        for (int i = 0; i < 5; i++) begin
            out_en = 1'b1; addr_out = 0; io_out = NUBITS'(16'hA000 + i);
            step();
        end
        idle();
        req_in = 1'b1; addr_in = ST;
        #1 chk("status_txfull_ovf", io_in, 16'h0006);
        step();
        idle();
        txlog.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("tx_drain_len", txlog.size(), 4);
        for (int i = 0; i < 4; i++) chk("tx_drain_word", txlog[i], NUBITS'(16'hA000 + i));

        // rx full with simultaneous push and pop keeps occupancy at depth
        idle();
        for (int i = 0; i < IDEPTH; i++) begin
            rx_valid = 1'b1; rx_data = NUBITS'(16'h3000 + i); step();
        end
        rx_valid = 1'b1; rx_data = 16'h3004; req_in = 1'b1; addr_in = 0;
        step();
        idle();
        #1 chk("rx_full_hold", rx_ready, 1'b0);
        step();
        for (int i = 1; i <= IDEPTH; i++) begin
            req_in = 1'b1; addr_in = 0;
            #1 chk("rx_order", io_in, NUBITS'(16'h3000 + i));
            step();
        end
        idle(); step();

        // gpo write and gpi read
        out_en = 1'b1; addr_out = 2; io_out = 16'hBEEF; step();
        idle();
        #1 chk("gpo_beef", gpo[NUBITS +: NUBITS], 16'hBEEF);
        req_in = 1'b1; addr_in = 1;
        #1 chk("gpi_port1", io_in, gpi[0 +: NUBITS]);
        step();

        // Reset mid-transfer with 3 words in each FIFO
        idle();
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = NUBITS'(16'h5000 + i);
            out_en = 1'b1; addr_out = 0; io_out = NUBITS'(16'h6000 + i);
            step();
        end
        idle();
        out_en = 1'b1; addr_out = 1; io_out = 16'h1234; step();
        idle();
        #2 rst = 1'b1;
        req_in = 1'b1; addr_in = ST;
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_gpo", gpo, '0);
        chk("rst_status", io_in, 16'h0000);
        chk("rst_rx_ready", rx_ready, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        tx_ready = 1'b1;
        req_in = 1'b1; addr_in = 0;
        #1 chk("post_rst_rx", io_in, 16'h0000);
        step();
        idle(); tx_ready = 1'b1;
        #1 chk("post_rst_tx", tx_valid, 1'b0);
        step();
        addr_in = ST; req_in = 1'b1; step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) gpi = NGPI*NUBITS'($urandom);
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = NUBITS'($urandom);
            req_in   = 1'($urandom_range(0, 1));
            addr_in  = NBIOIN'($urandom);
            out_en   = 1'($urandom_range(0, 1));
            addr_out = NBIOOU'($urandom);
            io_out   = NUBITS'($urandom);
            tx_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
